inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction fetch stage upstream of decode/execute in the CPU. Owns the fetch PC and
//  issues word reads to a variable-latency instruction memory. Buffers returned words in
//  an in-order prefetch queue and hands {inst, pc, pc+4} to decode via valid/ready.
//  Taken-branch/jal/jalr redirects from execute flush the queue and discard in-flight data.
// PARAMETERS
//  DEPTH     4    prefetch queue entries; power of 2, >=2; also the cap on queued + outstanding
//  RESET_PC  0    fetch address after reset; [1:0] must be 00
// PORTS
//  clk             in   1   clock, all state on rising edge
//  reset           in   1   synchronous, active-high
//  mem_req_valid   out  1   read request to imem
//  mem_req_ready   in   1   imem accepts request this cycle
//  mem_req_addr    out  32  word-aligned fetch address
//  mem_resp_valid  in   1   read data returned, in request order, 1 per accepted request
//  mem_resp_data   in   32  instruction word
//  redirect_valid  in   1   execute redirects fetch (branch taken / jal / jalr)
//  redirect_pc     in   32  redirect target
//  halt            in   1   ecall halt seen; stop fetching
//  inst_valid      out  1   queue head valid to decode
//  inst_ready      in   1   decode consumes head
//  inst            out  32  head instruction
//  inst_pc         out  32  head PC
//  inst_pc_plus4   out  32  head PC + 4 (mod 2^32)
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, state=RUN;
//   mem_req_valid=0, inst_valid=0 during reset cycle; inst/inst_pc/inst_pc_plus4 = 0.
//  FSM: RUN -> FLUSH on redirect when outstanding (after this cycle) > 0; FLUSH -> RUN when
//   drop_cnt reaches 0; RUN/FLUSH -> HALTED on halt=1; HALTED exits only by reset.
//  Issue (RUN only): mem_req_valid = (queue_count + outstanding < DEPTH) & ~redirect_valid & ~halt.
//   Never depends on mem_req_ready. Accept = valid & ready -> outstanding++, fetch_pc += 4 (wraps).
//   Address held stable while valid & ~ready; request may be withdrawn only by redirect/halt.
//  Response: mem_resp_valid with drop_cnt>0 -> discarded, drop_cnt--, outstanding--.
//   Otherwise written at queue tail with pc = tag FIFO entry; outstanding--. Response with
//   outstanding==0 is ignored. Earliest data visible on inst_valid the cycle after response.
//  Output: inst_valid = queue non-empty; head pops when inst_valid & inst_ready.
//   Push and pop in same cycle allowed when full (count unchanged). Pointers wrap mod DEPTH.
//  Redirect (any state except HALTED): queue emptied (inst_valid=0 next cycle);
//   fetch_pc = {redirect_pc[31:2],2'b00}; drop_cnt = outstanding after this cycle's accept and
//   response (same-cycle accepted request is dropped, same-cycle response is dropped).
//   Same-cycle pop completes before flush. Redirect during FLUSH adds nothing new; drop_cnt
//   already covers all in flight. New requests resume first cycle drop_cnt==0.
//  Halt: no new requests; queued entries still drain to decode; in-flight responses still
//   enqueued. Halt and redirect together -> halt wins, redirect ignored.
//  Widths: outstanding, drop_cnt, count are $clog2(DEPTH+1) bits; never exceed DEPTH.
//  Reset mid-operation clears everything; imem must be reset in the same cycle.
// TESTING
//  1 imem ready=1, 1-cycle resp, inst_ready=1 -> inst_pc 0x0,0x4,0x8,... one per cycle after fill.
//  2 inst_ready=0, DEPTH=4 -> exactly 4 requests accepted, then mem_req_valid=0; release ->
//    pcs 0x0,0x4,0x8,0xC in order, inst_pc_plus4 = 0x4..0x10.
//  3 2 in flight, redirect_pc=0x100 -> next 2 responses discarded, next inst_pc=0x100,
//    inst_valid=0 cycle after redirect.
//  4 redirect_pc=0x103 -> mem_req_addr=0x100; mem_req_ready=0 for 3 cycles -> addr stable.
//  5 halt=1 with 2 queued, 1 in flight -> no new requests, 3 instructions delivered, then
//    inst_valid stays 0; redirect afterwards ignored.
//  6 reset asserted with queue full and 2 outstanding -> next cycle all cleared,
//    first request addr=RESET_PC; fetch_pc 0xFFFFFFFC wraps to 0x0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Instruction fetch stage. Owns the fetch PC, issues word reads to a
//   variable-latency instruction memory, and keeps the returned words in an
//   in-order prefetch queue. Decode sees the queue head as {inst, pc, pc+4}
//   through a valid/ready handshake. Redirects from execute flush the queue,
//   and any responses still in flight at that point are discarded.
//
// Ports
//   clk, reset                       clock and synchronous active-high reset
//   mem_req_valid/ready/addr         word read request channel to imem
//   mem_resp_valid/data              in-order read data from imem
//   redirect_valid/redirect_pc       taken branch / jal / jalr target from execute
//   halt                             stop fetching (ecall); only reset restarts
//   inst_valid/ready                 handshake to decode
//   inst/inst_pc/inst_pc_plus4       queue head contents (zero while empty)
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;

  // Prefetch queue (instruction + its PC) and the tag FIFO holding the PC of
  // every request still waiting for its response.
  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   tag_pc [DEPTH];
  logic [PW-1:0] q_head, q_tail;
  logic [PW-1:0] tag_head, tag_tail;

  logic [CW:0]   occupancy;
  logic          accept;
  logic          resp_take;
  logic          resp_drop;
  logic          push;
  logic          pop;
  logic          do_redirect;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop_cnt_next;
  logic          unused_redirect_bits;

  // Queued plus in-flight words are capped at DEPTH so every response that
  // comes back is guaranteed a queue slot.
  assign occupancy     = {1'b0, count} + {1'b0, outstanding};
  assign mem_req_valid = ~reset & (state == RUN) & (occupancy < (CW+1)'(DEPTH))
                         & ~redirect_valid & ~halt;
  assign mem_req_addr  = fetch_pc;
  assign accept        = mem_req_valid & mem_req_ready;

  // A response only counts when something is actually outstanding; it is
  // thrown away while drop_cnt still covers stale requests.
  assign resp_take   = mem_resp_valid & (outstanding != '0);
  assign resp_drop   = resp_take & (drop_cnt != '0);
  assign do_redirect = redirect_valid & ~halt & (state != HALTED);
  assign push        = resp_take & ~resp_drop & ~do_redirect;
  assign pop         = inst_valid & inst_ready;

  assign outstanding_next = outstanding + CW'(accept) - CW'(resp_take);

  // On a redirect everything still in flight after this cycle becomes stale.
  // While already flushing, drop_cnt equals outstanding, so reloading it is
  // harmless.
  assign drop_cnt_next = do_redirect ? outstanding_next :
                         resp_drop   ? drop_cnt - 1'b1  : drop_cnt;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Decode outputs read the queue head directly and are forced to zero while
  // the queue is empty or the unit is in reset.
  assign inst_valid    = ~reset & (count != '0);
  assign inst          = inst_valid ? q_inst[q_head] : 32'h0;
  assign inst_pc       = inst_valid ? q_pc[q_head] : 32'h0;
  assign inst_pc_plus4 = inst_valid ? q_pc[q_head] + 32'd4 : 32'h0;

  // Storage arrays carry no reset; validity is tracked by pointers and count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept) begin
        tag_pc[tag_tail] <= fetch_pc;
      end
      if (push) begin
        q_inst[q_tail] <= mem_resp_data;
        q_pc[q_tail]   <= tag_pc[tag_head];
      end
    end
  end

  // Control state: fetch PC, counters, pointers and the RUN/FLUSH/HALTED FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      tag_head    <= '0;
      tag_tail    <= '0;
    end else begin
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;

      // The tag FIFO stays aligned with outstanding, dropped responses included.
      if (accept) begin
        tag_tail <= tag_tail + 1'b1;
      end
      if (resp_take) begin
        tag_head <= tag_head + 1'b1;
      end

      // Requests are suppressed during a redirect, so accept and redirect
      // never update fetch_pc in the same cycle.
      if (do_redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      // A pop in the redirect cycle has already been taken by decode, so
      // clearing the whole queue is correct.
      if (do_redirect) begin
        q_head <= '0;
        q_tail <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          q_tail <= q_tail + 1'b1;
        end
        if (pop) begin
          q_head <= q_head + 1'b1;
        end
        count <= count + CW'(push) - CW'(pop);
      end

      case (state)
        RUN: begin
          if (halt) begin
            state <= HALTED;
          end else if (do_redirect && (outstanding_next != '0)) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (halt) begin
            state <= HALTED;
          end else if (drop_cnt_next == '0) begin
            state <= RUN;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//   Drives the fetch unit with a behavioural instruction memory and checks it
//   against a queue-based reference model: a list of in-flight requests
//   (each marked live or stale) and a list of PCs ready for decode. Directed
//   scenarios run first, followed by randomized episodes.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clock),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc_plus4  (inst_pc_plus4)
  );

  typedef struct {
    logic [31:0] addr;
    bit          live;
  } req_t;

  // Reference model state.
  req_t        pending[$];
  logic [31:0] live_q[$];
  logic [31:0] exp_fetch;
  bit          halted;

  int checks;
  int failures;
  int accepts;
  int delivered;
  logic [31:0] first_pc;

  always #5 clock = ~clock;

  // Contents of the behavioural instruction memory at a given address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs, then
  // advance the reference model by what the coming rising edge does.
  task automatic applyStimulus(input bit rst, input bit rdy, input bit iready,
                               input bit redir, input logic [31:0] target,
                               input bit hlt, input int resp_pct);
    bit   resp;
    bit   exp_req;
    bit   stale;
    req_t r;
    @(negedge clock);
    reset          = rst;
    mem_req_ready  = rdy;
    inst_ready     = iready;
    redirect_valid = redir;
    redirect_pc    = target;
    halt           = hlt;
    resp           = !rst && (pending.size() > 0) && (int'($urandom_range(99)) < resp_pct);
    mem_resp_valid = resp;
    mem_resp_data  = resp ? memWord(pending[0].addr) : $urandom;
    #1;
    if (rst) begin
      checkOutput("reset_req_valid", 32'(mem_req_valid), 32'h0);
      checkOutput("reset_inst_valid", 32'(inst_valid), 32'h0);
      pending.delete();
      live_q.delete();
      exp_fetch = RESET_PC;
      halted    = 0;
    end else begin
      stale = 0;
      foreach (pending[i]) if (!pending[i].live) stale = 1;
      exp_req = !halted && !hlt && !redir && !stale &&
                (live_q.size() + pending.size() < DEPTH);
      checkOutput("req_valid", 32'(mem_req_valid), 32'(exp_req));
      if (mem_req_valid) checkOutput("req_addr", mem_req_addr, exp_fetch);
      checkOutput("inst_valid", 32'(inst_valid), 32'(live_q.size() > 0));

      if (live_q.size() > 0 && iready) begin
        checkOutput("inst_pc", inst_pc, live_q[0]);
        checkOutput("inst", inst, memWord(live_q[0]));
        checkOutput("inst_pc_plus4", inst_pc_plus4, live_q[0] + 32'd4);
        if (delivered == 0) first_pc = inst_pc;
        delivered++;
        void'(live_q.pop_front());
      end
      if (mem_req_valid && rdy) begin
        pending.push_back('{addr: mem_req_addr, live: 1'b1});
        exp_fetch = exp_fetch + 32'd4;
        accepts++;
      end
      if (resp) begin
        r = pending.pop_front();
        if (r.live && !(redir && !halted && !hlt)) live_q.push_back(r.addr);
      end
      if (hlt) begin
        halted = 1;
      end else if (redir && !halted) begin
        live_q.delete();
        foreach (pending[i]) pending[i].live = 0;
        exp_fetch = {target[31:2], 2'b00};
      end
    end
    @(posedge clock);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 32'h0, 0, 0);
    accepts   = 0;
    delivered = 0;
  endtask

  initial begin
    logic [31:0] tgt;
    int          pct;
    clock = 0; reset = 1; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    redirect_valid = 0; redirect_pc = 0; halt = 0; inst_ready = 0;
    checks = 0; failures = 0; accepts = 0; delivered = 0; first_pc = 0;
    pending.delete(); live_q.delete(); exp_fetch = RESET_PC; halted = 0;

    // Reset values of the decode outputs.
    doReset();
    #1;
    checkOutput("post_reset_inst", inst, 32'h0);
    checkOutput("post_reset_pc", inst_pc, 32'h0);
    checkOutput("post_reset_pc4", inst_pc_plus4, 32'h0);

    // Streaming with a 1-cycle memory: one instruction per cycle after fill.
    doReset();
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 1, 0, 32'h0, 0, 100);
    checkOutput("stream_delivered", 32'(delivered), 32'd10);
    checkOutput("stream_first_pc", first_pc, RESET_PC);

    // Decode stalled: exactly DEPTH requests, then drain in order.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 32'h0, 0, 100);
    checkOutput("stall_accepts", 32'(accepts), 32'(DEPTH));
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0, 32'h0, 0, 100);
    checkOutput("stall_delivered", 32'(delivered), 32'(DEPTH));

    // Redirect with two in flight; stale responses are discarded.
    doReset();
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 0, 32'h0, 0, 0);
    applyStimulus(0, 1, 1, 1, 32'h100, 0, 0);
    delivered = 0;
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, 0, 32'h0, 0, 100);
    checkOutput("redirect_first_pc", first_pc, 32'h100);

    // Misaligned redirect target with imem back-pressure.
    applyStimulus(0, 0, 1, 1, 32'h103, 0, 100);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 32'h0, 0, 100);
    accepts = 0;
    applyStimulus(0, 1, 1, 0, 32'h0, 0, 100);
    checkOutput("aligned_accept", 32'(accepts), 32'd1);

    // Halt with two queued and one in flight; redirect afterwards ignored.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 32'h0, 0, 100);
    applyStimulus(0, 1, 0, 0, 32'h0, 1, 0);
    delivered = 0;
    applyStimulus(0, 1, 1, 1, 32'h200, 0, 100);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 0, 32'h0, 0, 100);
    checkOutput("halt_delivered", 32'(delivered), 32'd3);

    // Fetch PC wrap at the top of the address space.
    doReset();
    applyStimulus(0, 1, 1, 1, 32'hFFFF_FFFC, 0, 100);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 0, 32'h0, 0, 100);

    // Randomized episodes, including mid-run resets.
    for (int ep = 0; ep < 20; ep++) begin
      doReset();
      pct = 30 + int'($urandom_range(60));
      for (int c = 0; c < 200; c++) begin
        tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
        applyStimulus($urandom_range(99) == 0, $urandom_range(9) < 7,
                      $urandom_range(9) < 6, $urandom_range(19) == 0, tgt,
                      $urandom_range(299) == 0, pct);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
